// File: rtl/xnor_psum_accumulator.sv
// xnor_psum_accumulator: accumulates per-lane signed popcount partial sums over
// cfg_num_ch beats, then binarizes each lane sum against a shared threshold.
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   cfg_num_ch          beats per output pixel (0 behaves as 1)
//   cfg_threshold       signed binarization threshold
//   in_valid/in_ready   partial-sum beat handshake, in_psum lane i at [PSUM_W*i +: PSUM_W]
//   out_valid/out_ready result handshake
//   out_bits            per-lane (sum >= threshold)
//   out_acc             raw signed lane sums, lane i at [ACC_W*i +: ACC_W]
//   out_sat             per-lane sticky saturation flag for the pixel
//   busy                pixel in progress or result pending
module xnor_psum_accumulator #(
    parameter int NUMHELPER = 4,
    parameter int PSUM_W    = 6,
    parameter int ACC_W     = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [7:0]                    cfg_num_ch,
    input  logic [ACC_W-1:0]              cfg_threshold,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUMHELPER*PSUM_W-1:0]   in_psum,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUMHELPER-1:0]          out_bits,
    output logic [NUMHELPER*ACC_W-1:0]    out_acc,
    output logic [NUMHELPER-1:0]          out_sat,
    output logic                          busy
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    logic [1:0]              state;
    logic [7:0]              n_lat, cnt, n_new;
    logic signed [ACC_W-1:0] thr_lat, thr_eff;
    logic signed [ACC_W-1:0] acc [NUMHELPER];
    logic signed [ACC_W-1:0] sum_c [NUMHELPER];
    logic [NUMHELPER-1:0]    sat, sat_c, bit_c;
    logic                    accept, first, last;

    assign in_ready  = state == HOLD ? out_ready : 1'b1;
    assign out_valid = state == HOLD;
    assign busy      = state != IDLE;
    assign accept    = in_valid && in_ready;
    // Any accept outside ACCUM starts a new pixel, including the one that
    // coincides with consuming the held result.
    assign first     = state != ACCUM;
    assign n_new     = cfg_num_ch == 8'd0 ? 8'd1 : cfg_num_ch;
    assign last      = first ? n_new == 8'd1 : cnt + 8'd1 == n_lat;
    assign thr_eff   = first ? signed'(cfg_threshold) : thr_lat;

    for (genvar i = 0; i < NUMHELPER; i++) begin : g_lane
        logic signed [PSUM_W-1:0] ps;
        logic signed [ACC_W:0]    base, ext, wide;
        logic                     ovf;
        assign ps   = in_psum[PSUM_W*i +: PSUM_W];
        assign base = first ? '0 : (ACC_W+1)'(acc[i]);
        assign ext  = (ACC_W+1)'(ps);
        assign wide = base + ext;
        // One guard bit: overflow when it disagrees with the sign bit; clamp toward its sign.
        assign ovf       = wide[ACC_W] != wide[ACC_W-1];
        assign sum_c[i]  = ovf ? {wide[ACC_W], {(ACC_W-1){~wide[ACC_W]}}} : wide[ACC_W-1:0];
        assign sat_c[i]  = ovf | (!first && sat[i]);
        assign bit_c[i]  = sum_c[i] >= thr_eff;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            n_lat    <= '0;
            cnt      <= '0;
            thr_lat  <= '0;
            sat      <= '0;
            out_bits <= '0;
            out_acc  <= '0;
            out_sat  <= '0;
            for (int k = 0; k < NUMHELPER; k++) acc[k] <= '0;
        end else if (accept) begin
            cnt   <= first ? 8'd1 : cnt + 8'd1;
            sat   <= sat_c;
            state <= last ? HOLD : ACCUM;
            for (int k = 0; k < NUMHELPER; k++) acc[k] <= sum_c[k];
            if (first) begin
                n_lat   <= n_new;
                thr_lat <= cfg_threshold;
            end
            if (last) begin
                out_bits <= bit_c;
                out_sat  <= sat_c;
                for (int k = 0; k < NUMHELPER; k++) out_acc[ACC_W*k +: ACC_W] <= sum_c[k];
            end
        end else if (state == HOLD && out_ready) begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_xnor_psum_accumulator.sv
// tb_xnor_psum_accumulator: directed self-checking bench for xnor_psum_accumulator.
module tb_xnor_psum_accumulator;
    logic        clock = 0;
    logic        reset = 1;
    logic [7:0]  cfg_num_ch = 0;
    logic [15:0] cfg_threshold = 0;
    logic        in_valid = 0;
    logic [23:0] in_psum = 0;
    logic        out_ready = 0;
    logic        in_ready, out_valid, busy;
    logic [3:0]  out_bits, out_sat;
    logic [63:0] out_acc;
    logic        ready8, valid8, busy8;
    logic [3:0]  bits8, sat8;
    logic [31:0] acc8;
    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    xnor_psum_accumulator dut (
        .clock(clock), .reset(reset), .cfg_num_ch(cfg_num_ch), .cfg_threshold(cfg_threshold),
        .in_valid(in_valid), .in_ready(in_ready), .in_psum(in_psum), .out_valid(out_valid),
        .out_ready(out_ready), .out_bits(out_bits), .out_acc(out_acc), .out_sat(out_sat), .busy(busy)
    );

    xnor_psum_accumulator #(.ACC_W(8)) dut8 (
        .clock(clock), .reset(reset), .cfg_num_ch(cfg_num_ch), .cfg_threshold(cfg_threshold[7:0]),
        .in_valid(in_valid), .in_ready(ready8), .in_psum(in_psum), .out_valid(valid8),
        .out_ready(out_ready), .out_bits(bits8), .out_acc(acc8), .out_sat(sat8), .busy(busy8)
    );

    function automatic logic [23:0] pk(input int a, input int b, input int c, input int d);
        return {6'(d), 6'(c), 6'(b), 6'(a)};
    endfunction

    function automatic logic [63:0] ea(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [23:0] p);
        int t = 0;
        in_valid = 1;
        in_psum  = p;
        while (!in_ready && t < 20) begin
            step();
            t++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
        end
        step();
    endtask

    task automatic test_reset();
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: valid=%0b ready=%0b busy=%0b required 0 1 0", out_valid, in_ready, busy);
        end
        checks++;
        if (out_acc !== 64'd0 || out_bits !== 4'd0 || out_sat !== 4'd0) begin
            errors++;
            $display("FAIL reset_data: acc=%h bits=%b sat=%b required all 0", out_acc, out_bits, out_sat);
        end
        reset = 0;
        step();
    endtask

    task automatic test_basic();
        cfg_num_ch = 3; cfg_threshold = 0; out_ready = 0;
        send(pk(5, -2, 0, 25));
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_beat1: valid=%0b busy=%0b required 0 1", out_valid, busy);
        end
        send(pk(5, -2, 0, 25));
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_beat2: valid=%0b required 0", out_valid);
        end
        send(pk(5, -2, 0, 25));
        in_valid = 0;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_latency: valid=%0b required 1", out_valid);
        end
        checks++;
        if (out_acc !== ea(15, -6, 0, 75) || out_bits !== 4'b1101 || out_sat !== 4'b0000) begin
            errors++;
            $display("FAIL basic_result: acc=%h bits=%b sat=%b required %h 1101 0000", out_acc, out_bits, out_sat, ea(15, -6, 0, 75));
        end
        out_ready = 1;
        step();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_consume: valid=%0b busy=%0b required 0 0", out_valid, busy);
        end
    endtask

    task automatic test_num_ch_zero();
        cfg_num_ch = 0; cfg_threshold = 0; out_ready = 0;
        send(pk(-1, 1, -25, 0));
        in_valid = 0;
        checks++;
        if (out_valid !== 1'b1 || out_bits !== 4'b1010 || out_acc !== ea(-1, 1, -25, 0)) begin
            errors++;
            $display("FAIL num_ch_zero: valid=%0b bits=%b acc=%h required 1 1010 %h", out_valid, out_bits, out_acc, ea(-1, 1, -25, 0));
        end
        out_ready = 1;
        step();
    endtask

    task automatic test_saturation();
        cfg_num_ch = 8; cfg_threshold = 0; out_ready = 1;
        for (int b = 0; b < 8; b++) send(pk(25, 25, 25, 25));
        in_valid = 0;
        checks++;
        if (valid8 !== 1'b1 || acc8 !== 32'h7F7F7F7F || sat8 !== 4'hF || bits8 !== 4'hF) begin
            errors++;
            $display("FAIL sat_acc8: valid=%0b acc=%h sat=%h bits=%h required 1 7f7f7f7f f f", valid8, acc8, sat8, bits8);
        end
        checks++;
        if (out_acc !== ea(200, 200, 200, 200) || out_sat !== 4'h0) begin
            errors++;
            $display("FAIL sat_acc16: acc=%h sat=%h required %h 0", out_acc, out_sat, ea(200, 200, 200, 200));
        end
        step();
    endtask

    task automatic test_backpressure();
        cfg_num_ch = 1; cfg_threshold = 0; out_ready = 0;
        send(pk(1, 2, 3, 4));
        in_psum = pk(2, 2, 2, 2);
        cfg_num_ch = 2;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_acc !== ea(1, 2, 3, 4) || out_bits !== 4'hF) begin
                errors++;
                $display("FAIL hold_stable cycle %0d: ready=%0b valid=%0b acc=%h bits=%b required 0 1 %h 1111", c, in_ready, out_valid, out_acc, out_bits, ea(1, 2, 3, 4));
            end
            step();
        end
        out_ready = 1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: in_ready=%0b required 1", in_ready);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL no_bubble_accept: valid=%0b busy=%0b required 0 1", out_valid, busy);
        end
        in_psum = pk(3, 3, 3, 3);
        step();
        in_valid = 0;
        checks++;
        if (out_valid !== 1'b1 || out_acc !== ea(5, 5, 5, 5) || out_bits !== 4'hF) begin
            errors++;
            $display("FAIL back_to_back: valid=%0b acc=%h bits=%b required 1 %h 1111", out_valid, out_acc, out_bits, ea(5, 5, 5, 5));
        end
        step();
    endtask

    task automatic test_reset_mid();
        cfg_num_ch = 4; cfg_threshold = 0; out_ready = 1;
        send(pk(10, 10, 10, 10));
        send(pk(10, 10, 10, 10));
        in_valid = 0;
        reset = 1;
        #1;
        checks++;
        if (out_acc !== 64'd0 || out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out_bits !== 4'd0) begin
            errors++;
            $display("FAIL reset_mid: acc=%h valid=%0b busy=%0b ready=%0b bits=%b required 0 0 0 1 0", out_acc, out_valid, busy, in_ready, out_bits);
        end
        step();
        reset = 0;
        step();
        for (int b = 0; b < 3; b++) send(pk(1, -1, 2, -2));
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_fresh_beat3: valid=%0b required 0", out_valid);
        end
        send(pk(1, -1, 2, -2));
        in_valid = 0;
        checks++;
        if (out_valid !== 1'b1 || out_acc !== ea(4, -4, 8, -8) || out_bits !== 4'b0101) begin
            errors++;
            $display("FAIL reset_fresh: valid=%0b acc=%h bits=%b required 1 %h 0101", out_valid, out_acc, out_bits, ea(4, -4, 8, -8));
        end
        step();
    endtask

    task automatic test_cfg_change();
        cfg_num_ch = 2; cfg_threshold = 0; out_ready = 1;
        send(pk(5, 5, 5, 5));
        cfg_threshold = 100;
        cfg_num_ch = 1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL cfg_n_latched: valid=%0b required 0", out_valid);
        end
        send(pk(5, 5, 5, 5));
        in_valid = 0;
        checks++;
        if (out_valid !== 1'b1 || out_acc !== ea(10, 10, 10, 10) || out_bits !== 4'hF) begin
            errors++;
            $display("FAIL cfg_thr_latched: valid=%0b acc=%h bits=%b required 1 %h 1111", out_valid, out_acc, out_bits, ea(10, 10, 10, 10));
        end
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_num_ch_zero();
        test_saturation();
        test_backpressure();
        test_reset_mid();
        test_cfg_change();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
